pulse_sched_mc: RTL and testbench
=================================

// Module: pulse_sched_mc
// PURPOSE
//  Parametrised multi-channel timed pulse scheduler; successor to the single-stream scheduler.
//  - Buffers timestamped pulse instructions from the core in an in-order FIFO.
//  - Runs a free-running time counter.
//  - Fires a one-cycle strobe on the addressed output channel when the counter reaches the instruction timestamp.
//  - Sits between the RISC-V pulse-instruction port and the per-qubit pulse generators.
// PARAMETERS
//  INST_W   32   instruction width; fields: [TS_W-1:0]=timestamp, [TS_W+3:TS_W]=channel, [INST_W-1:TS_W+4]=payload
//  TS_W     20   timestamp / time-counter width
//  NUM_CH   4    output channels, 1..16
//  DEPTH    16   FIFO entries, power of 2, >=2
//  PL_W     INST_W-TS_W-4   payload width (derived localparam, 8 at defaults)
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 synchronous reset, active-high
//  in_inst          in   INST_W            pulse instruction
//  in_valid         in   1                 instruction valid
//  in_ready         out  1                 FIFO can accept (= !full)
//  run              in   1                 1: time counter advances and issue enabled
//  time_clr         in   1                 synchronous clear of time counter
//  err_clr          in   1                 clears err_ch_o and late_cnt_o
//  time_o           out  TS_W              current time counter
//  pulse_o          out  NUM_CH            one-hot fire strobe, 1 cycle
//  pulse_payload_o  out  PL_W              payload of fired instruction, valid with pulse_o
//  pulse_late_o     out  1                 fired instruction was late, valid with pulse_o
//  fifo_level_o     out  $clog2(DEPTH+1)   entries held
//  late_cnt_o       out  16                late-issue count, saturates at 16'hFFFF
//  err_ch_o         out  1                 sticky: instruction with channel >= NUM_CH seen
// BEHAVIOUR
//  - Reset: FIFO flushed; time_o=0; pulse_o=0; payload=0; late=0; level=0; late_cnt=0; err=0; in_ready=1.
//    Reset mid-operation discards all pending entries; no pulse is emitted in the cycle after rst.
//  - Enqueue: push on in_valid&&in_ready. No push when full, even if a pop occurs the same cycle.
//    Simultaneous push+pop when not full leaves the level unchanged.
//  - Time counter: if time_clr, next=0 (time_clr has priority over run); else if run, next=time_o+1 mod 2^TS_W; else hold.
//  - Head compare: d = (head.ts - time_o) mod 2^TS_W.
//    d==0 -> due; d[TS_W-1]==1 -> late; otherwise future. Wrap-around is handled by the modular difference.
//    Scheduling window is 2^(TS_W-1) cycles.
//  - Issue: only when run=1 and the FIFO is non-empty; at most one pop per cycle, strictly in order.
//    Due or late head is popped. Outputs are registered, so pulse_o[ch] is high in the cycle after the compare.
//    This gives a fixed latency of 1 (pulse seen while time_o==ts+1 for an on-time issue).
//  - Late: pulse_late_o=1 with the strobe; late_cnt_o increments, saturating.
//  - Bad channel: head with ch>=NUM_CH is popped when due/late with no strobe; err_ch_o set sticky; not counted as late.
//  - Same timestamp twice: first fires on time; second fires next cycle as late.
//  - run=0: no pops, counter holds, pulse_o=0.
//  - time_clr with entries pending: entries are compared against the new time as-is (no flush).
//  - err_clr: clears err_ch_o and late_cnt_o; set/increment in the same cycle wins over clear.
//  - pulse_o, pulse_payload_o and pulse_late_o return to 0 in any cycle without an issue.
// CONFIGURATION
//  PULSE_SCHED_LATE_DROP_EN
//  - Defined: late head is popped and dropped; no strobe; late_cnt_o still increments; pulse_late_o tied 0.
//  - Undefined: late head fires immediately with pulse_late_o=1 (default).
// TESTING
//  1. rst; run=1 from t=0; push {pl=8'hA5,ch=2,ts=20'd10} -> pulse_o=4'b0100, payload A5, late=0, while time_o==11.
//  2. Push ts=5,ch=0 and ts=5,ch=1 before t=5
//     -> ch0 fires while time_o==6 with late=0; ch1 fires while time_o==7 with late=1; late_cnt_o=1.
//  3. run=0; push 16 entries -> in_ready=0, fifo_level_o=16; 17th push ignored; 17th valid held until ready.
//  4. Counter near wrap (time_o=20'hFFFF0); push ts=20'h00005 -> no early fire; fires while time_o==20'h00006.
//  5. Push ch=7 (NUM_CH=4), ts=3 -> no strobe, err_ch_o=1 from the cycle after pop; err_clr -> 0.
//  6. rst asserted with 5 entries pending -> next cycle level=0, no pulses; with DROP_EN, case 2 ch1 has no strobe.

Source files
------------

// File: rtl/pulse_sched_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pulse_sched_mc                                                |
// | Purpose  : Multi-channel timed pulse scheduler. Timestamped instructions |
// |            are queued in order and fire a one-cycle channel strobe when  |
// |            the free-running time counter reaches their timestamp.        |
// | Options  : PULSE_SCHED_LATE_DROP_EN - drop late instructions silently.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pulse_sched_mc #(
    parameter int INST_W = 32,
    parameter int TS_W   = 20,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    localparam int PL_W  = INST_W - TS_W - 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              run,
    input  logic              time_clr,
    input  logic              err_clr,
    output logic [TS_W-1:0]   time_o,
    output logic [NUM_CH-1:0] pulse_o,
    output logic [PL_W-1:0]   pulse_payload_o,
    output logic              pulse_late_o,
    output logic [LVL_W-1:0]  fifo_level_o,
    output logic [15:0]       late_cnt_o,
    output logic              err_ch_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INST_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [TS_W-1:0]   r_time;
    logic [NUM_CH-1:0] r_pulse;
    logic [PL_W-1:0]   r_payload;
    logic [15:0]       r_late_cnt;
    logic              r_err_ch;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [INST_W-1:0] w_head;
    logic [TS_W-1:0]   w_head_ts;
    logic [3:0]        w_head_ch;
    logic [PL_W-1:0]   w_head_pl;
    logic [TS_W-1:0]   w_diff;
    logic              w_due;
    logic              w_late;
    logic              w_ch_ok;
    logic              w_fire;
    logic              w_late_evt;
    logic [NUM_CH-1:0] w_onehot;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = in_valid && !w_full;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_ts = w_head[TS_W-1:0];
    assign w_head_ch = w_head[TS_W+3:TS_W];
    assign w_head_pl = w_head[INST_W-1:TS_W+4];

    // Modular difference: MSB set means the timestamp is behind the counter.
    assign w_diff  = w_head_ts - r_time;
    assign w_due   = (w_diff == '0);
    assign w_late  = w_diff[TS_W-1];
    assign w_pop   = run && !w_empty && (w_due || w_late);
    assign w_ch_ok = ({1'b0, w_head_ch} < 5'(NUM_CH));

`ifdef PULSE_SCHED_LATE_DROP_EN
    assign w_fire = w_pop && w_ch_ok && !w_late;
`else
    assign w_fire = w_pop && w_ch_ok;
`endif
    assign w_late_evt = w_pop && w_ch_ok && w_late;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_onehot[i] = (w_head_ch == 4'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_time <= '0;
        end else if (time_clr) begin
            r_time <= '0;
        end else if (run) begin
            r_time <= r_time + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse   <= '0;
            r_payload <= '0;
        end else begin
            r_pulse   <= w_fire ? w_onehot : '0;
            r_payload <= w_fire ? w_head_pl : '0;
        end
    end

    // A late event or bad-channel pop in the same cycle takes precedence over err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_late_cnt <= '0;
            r_err_ch   <= 1'b0;
        end else begin
            if (w_late_evt) begin
                if (r_late_cnt != 16'hFFFF) r_late_cnt <= r_late_cnt + 16'd1;
            end else if (err_clr) begin
                r_late_cnt <= '0;
            end

            if (w_pop && !w_ch_ok) begin
                r_err_ch <= 1'b1;
            end else if (err_clr) begin
                r_err_ch <= 1'b0;
            end
        end
    end

`ifdef PULSE_SCHED_LATE_DROP_EN
    assign pulse_late_o = 1'b0;
`else
    logic r_late;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_late <= 1'b0;
        end else begin
            r_late <= w_fire && w_late;
        end
    end

    assign pulse_late_o = r_late;
`endif

    assign in_ready        = !w_full;
    assign time_o          = r_time;
    assign pulse_o         = r_pulse;
    assign pulse_payload_o = r_payload;
    assign fifo_level_o    = r_level;
    assign late_cnt_o      = r_late_cnt;
    assign err_ch_o        = r_err_ch;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sched_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pulse_sched_mc                                             |
// | Purpose  : Directed self-checking bench for pulse_sched_mc.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pulse_sched_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_inst;
    logic        in_valid;
    logic        in_ready;
    logic        run;
    logic        time_clr;
    logic        err_clr;
    logic [19:0] time_o;
    logic [3:0]  pulse_o;
    logic [7:0]  pulse_payload_o;
    logic        pulse_late_o;
    logic [4:0]  fifo_level_o;
    logic [15:0] late_cnt_o;
    logic        err_ch_o;

    // Narrow-counter instance used to exercise wrap-around in a short run.
    logic [19:0] wr_inst;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_run;
    logic        wr_time_clr;
    logic        wr_err_clr;
    logic [7:0]  wr_time;
    logic [3:0]  wr_pulse;
    logic [7:0]  wr_payload;
    logic        wr_late;
    logic [4:0]  wr_level;
    logic [15:0] wr_late_cnt;
    logic        wr_err_ch;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pulse_sched_mc #(.INST_W(32), .TS_W(20), .NUM_CH(4), .DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .in_inst(in_inst), .in_valid(in_valid), .in_ready(in_ready),
        .run(run), .time_clr(time_clr), .err_clr(err_clr), .time_o(time_o),
        .pulse_o(pulse_o), .pulse_payload_o(pulse_payload_o), .pulse_late_o(pulse_late_o),
        .fifo_level_o(fifo_level_o), .late_cnt_o(late_cnt_o), .err_ch_o(err_ch_o)
    );

    pulse_sched_mc #(.INST_W(20), .TS_W(8), .NUM_CH(4), .DEPTH(16)) u_dut_wrap (
        .clk(clk), .rst(rst), .in_inst(wr_inst), .in_valid(wr_valid), .in_ready(wr_ready),
        .run(wr_run), .time_clr(wr_time_clr), .err_clr(wr_err_clr), .time_o(wr_time),
        .pulse_o(wr_pulse), .pulse_payload_o(wr_payload), .pulse_late_o(wr_late),
        .fifo_level_o(wr_level), .late_cnt_o(wr_late_cnt), .err_ch_o(wr_err_ch)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (pulse_o != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        bit any_pulse;

        rst = 1'b1; in_inst = '0; in_valid = 1'b0; run = 1'b0; time_clr = 1'b0; err_clr = 1'b0;
        wr_inst = '0; wr_valid = 1'b0; wr_run = 1'b0; wr_time_clr = 1'b0; wr_err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check("rst_time",     64'(time_o), 64'd0);
        check("rst_pulse",    64'(pulse_o), 64'd0);
        check("rst_payload",  64'(pulse_payload_o), 64'd0);
        check("rst_late",     64'(pulse_late_o), 64'd0);
        check("rst_level",    64'(fifo_level_o), 64'd0);
        check("rst_ready",    64'(in_ready), 64'd1);
        check("rst_late_cnt", 64'(late_cnt_o), 64'd0);
        check("rst_err",      64'(err_ch_o), 64'd0);

        // On-time issue: ts=10 on channel 2 fires while time_o==11.
        in_inst = {8'hA5, 4'd2, 20'd10}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_level", 64'(fifo_level_o), 64'd1);
        run = 1'b1;
        wait_pulse(40, ok);
        check("t1_fired",   64'(ok), 64'd1);
        check("t1_pulse",   64'(pulse_o), 64'h4);
        check("t1_payload", 64'(pulse_payload_o), 64'hA5);
        check("t1_late",    64'(pulse_late_o), 64'd0);
        check("t1_time",    64'(time_o), 64'd11);
        tick();
        check("t1_pulse_off", 64'(pulse_o), 64'd0);
        check("t1_pl_off",    64'(pulse_payload_o), 64'd0);
        check("t1_level_end", 64'(fifo_level_o), 64'd0);

        // Same timestamp twice: second issue is late (or dropped).
        time_clr = 1'b1; in_inst = {8'h11, 4'd0, 20'd5}; in_valid = 1'b1;
        tick();
        time_clr = 1'b0; in_inst = {8'h22, 4'd1, 20'd5};
        tick();
        in_valid = 1'b0;
        check("t2_level", 64'(fifo_level_o), 64'd2);
        wait_pulse(20, ok);
        check("t2_fired",   64'(ok), 64'd1);
        check("t2_pulse0",  64'(pulse_o), 64'h1);
        check("t2_pl0",     64'(pulse_payload_o), 64'h11);
        check("t2_late0",   64'(pulse_late_o), 64'd0);
        check("t2_time0",   64'(time_o), 64'd6);
        tick();
`ifdef PULSE_SCHED_LATE_DROP_EN
        check("t2_pulse1",  64'(pulse_o), 64'h0);
        check("t2_late1",   64'(pulse_late_o), 64'd0);
`else
        check("t2_pulse1",  64'(pulse_o), 64'h2);
        check("t2_pl1",     64'(pulse_payload_o), 64'h22);
        check("t2_late1",   64'(pulse_late_o), 64'd1);
`endif
        check("t2_time1",    64'(time_o), 64'd7);
        check("t2_late_cnt", 64'(late_cnt_o), 64'd1);
        check("t2_level_end", 64'(fifo_level_o), 64'd0);

        // Bad channel: popped at ts=3 without a strobe, sets the sticky error.
        time_clr = 1'b1; in_inst = {8'h77, 4'd7, 20'd3}; in_valid = 1'b1;
        tick();
        time_clr = 1'b0; in_valid = 1'b0;
        any_pulse = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pulse_o != 4'd0) any_pulse = 1'b1;
            if (err_ch_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_err_set",  64'(ok), 64'd1);
        check("t5_err_time", 64'(time_o), 64'd4);
        check("t5_no_pulse", 64'(any_pulse), 64'd0);
        check("t5_level",    64'(fifo_level_o), 64'd0);
        check("t5_late_cnt", 64'(late_cnt_o), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_err_clr",  64'(err_ch_o), 64'd0);
        check("t5_cnt_clr",  64'(late_cnt_o), 64'd0);

        // Fill the FIFO with run=0; 17th valid waits until the first pop.
        run = 1'b0; time_clr = 1'b1;
        tick();
        time_clr = 1'b0;
        check("t3_time_clr", 64'(time_o), 64'd0);
        for (int i = 0; i < 16; i++) begin
            in_inst  = (i == 0) ? {8'h01, 4'd3, 20'd2} : {8'(i + 1), 4'd3, 20'h40000};
            in_valid = 1'b1;
            tick();
        end
        check("t3_full_level", 64'(fifo_level_o), 64'd16);
        check("t3_full_ready", 64'(in_ready), 64'd0);
        in_inst = {8'hEE, 4'd3, 20'h40000};
        tick(); tick(); tick();
        check("t3_ignored",    64'(fifo_level_o), 64'd16);
        check("t3_hold_time",  64'(time_o), 64'd0);
        run = 1'b1;
        wait_pulse(10, ok);
        check("t3_fired",   64'(ok), 64'd1);
        check("t3_pulse",   64'(pulse_o), 64'h8);
        check("t3_payload", 64'(pulse_payload_o), 64'h01);
        check("t3_time",    64'(time_o), 64'd3);
        check("t3_pop_level", 64'(fifo_level_o), 64'd15);
        check("t3_ready",   64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("t3_refill",  64'(fifo_level_o), 64'd16);

        // Reset with entries pending flushes everything.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_level", 64'(fifo_level_o), 64'd0);
        check("t6_pulse", 64'(pulse_o), 64'd0);
        check("t6_time",  64'(time_o), 64'd0);
        check("t6_ready", 64'(in_ready), 64'd1);
        any_pulse = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pulse_o != 4'd0) any_pulse = 1'b1;
        end
        check("t6_no_pulse", 64'(any_pulse), 64'd0);
        run = 1'b0;

        // Wrap-around on the 8-bit counter: ts=5 pushed at time 0xF0.
        wr_run = 1'b1;
        for (int i = 0; i < 240; i++) tick();
        check("t4_near_wrap", 64'(wr_time), 64'hF0);
        wr_inst = {8'h3C, 4'd1, 8'd5}; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr_pulse != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_fired",   64'(ok), 64'd1);
        check("t4_time",    64'(wr_time), 64'h06);
        check("t4_pulse",   64'(wr_pulse), 64'h2);
        check("t4_payload", 64'(wr_payload), 64'h3C);
        check("t4_late",    64'(wr_late), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
